// File: rtl/vram_arbiter_if.sv
// -----------------------------------------------------------------------------
// vram_arbiter_if
//
// Bundles every bus between the video RAM arbiter and its neighbours: the CPU
// request/ack port, the video fetch port, the single-port display RAM port and
// the power-on clear status flag.
//
// Modports:
//   slave  - the arbiter's view (drives responses, RAM controls, clear_busy)
//   master - the surrounding system's view (drives requests and ram_rdata)
//
// Signals:
//   cpu_req, cpu_we, cpu_addr, cpu_wdata  CPU request (level, held until ack)
//   cpu_rdata, cpu_ack                     CPU completion pulse and read data
//   vid_req, vid_addr                      video fetch pulse and address
//   vid_rdata, vid_valid                   fetched byte and its qualifier
//   ram_addr, ram_wdata, ram_we            RAM controls (grant cycle)
//   ram_rdata                              RAM read data, one cycle latency
//   clear_busy                             power-on clear in progress
// -----------------------------------------------------------------------------
interface vram_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_rdata;
    logic              vid_valid;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              clear_busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
        output cpu_rdata, cpu_ack, vid_rdata, vid_valid,
               ram_addr, ram_wdata, ram_we, clear_busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
        input  cpu_rdata, cpu_ack, vid_rdata, vid_valid,
               ram_addr, ram_wdata, ram_we, clear_busy
    );
endinterface

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Shares the single-port character RAM between the CPU bus and the display
// fetch path. Each cycle one source is granted and drives the RAM directly;
// video always wins, the CPU waits on a request/ack handshake. Read data comes
// back one cycle after the grant and is registered into the port that owned
// the grant, so every access (video or CPU, read or write) completes two
// cycles after its grant.
//
// Ports:
//   clk      system clock, rising edge
//   n_reset  asynchronous active-low reset
//   bus      vram_arbiter_if.slave (CPU, video, RAM ports and clear_busy)
//
// Build option:
//   VRAM_CLEAR_EN  when defined, every reset release starts a fill of the whole
//                  RAM with FILL (one address per cycle) before any requester
//                  is served; clear_busy is high meanwhile. When undefined the
//                  block comes out of reset idle and clear_busy is tied low.
// -----------------------------------------------------------------------------
module vram_arbiter #(
    parameter int                ADDR_W = 11,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] FILL   = 8'h20
) (
    input  logic          clk,
    input  logic          n_reset,
    vram_arbiter_if.slave bus
);

    // The state encodes the grant of a cycle; the registered copy therefore
    // doubles as the source tag of the read data arriving in the next cycle.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VID    = 3'd1,
        ST_CPU_RD = 3'd2,
        ST_CPU_WR = 3'd3
`ifdef VRAM_CLEAR_EN
        , ST_CLEAR = 3'd4
`endif
    } state_t;

`ifdef VRAM_CLEAR_EN
    localparam state_t ST_RESET = ST_CLEAR;
`else
    localparam state_t ST_RESET = ST_IDLE;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_d;
    logic              clearing;
    logic              fill_q, fill_d;
    logic              cpu_ack_q, vid_valid_q;
    logic [DATA_W-1:0] cpu_rdata_q, vid_rdata_q;
    logic              cpu_busy, cpu_pend;

`ifdef VRAM_CLEAR_EN
    // MSB of the counter is the terminal flag: it sets after the last address.
    logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;
    assign clearing = ~clr_cnt_q[ADDR_W];
`else
    assign clearing = 1'b0;
`endif

    // A CPU access is in flight from its grant until its ack cycle; in the ack
    // cycle the requester still holds cpu_req, so that cycle is masked too.
    assign cpu_busy = (state_q == ST_CPU_RD) || (state_q == ST_CPU_WR) || cpu_ack_q;
    assign cpu_pend = bus.cpu_req && !cpu_busy;

    // Video fetches during the clear are answered with FILL without touching RAM.
    assign fill_d = clearing && bus.vid_req;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q     <= ST_RESET;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
`ifdef VRAM_CLEAR_EN
            clr_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
`ifdef VRAM_CLEAR_EN
            clr_cnt_q   <= clr_cnt_d;
`endif
        end
    end

    // --------------------------------------------------------------- next state
    // The grant is decided combinationally from this cycle's requests. While
    // n_reset is low nothing is granted so the RAM port shows its reset values.
    always_comb begin
        state_d = ST_IDLE;
        if (n_reset) begin
            if (bus.vid_req) begin
                state_d = ST_VID;
            end else if (cpu_pend) begin
                state_d = bus.cpu_we ? ST_CPU_WR : ST_CPU_RD;
            end
`ifdef VRAM_CLEAR_EN
            if (clearing) begin
                state_d = ST_CLEAR;
            end
`endif
        end
`ifdef VRAM_CLEAR_EN
        clr_cnt_d = clr_cnt_q;
        if (state_d == ST_CLEAR) begin
            clr_cnt_d = clr_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
        end
`endif
    end

    // ------------------------------------------------------------------ outputs
    // Address and write data hold their last values when idle.
    always_comb begin
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        case (state_d)
            ST_VID: begin
                ram_addr_d = bus.vid_addr;
            end
            ST_CPU_RD: begin
                ram_addr_d = bus.cpu_addr;
            end
            ST_CPU_WR: begin
                ram_addr_d  = bus.cpu_addr;
                ram_wdata_d = bus.cpu_wdata;
                ram_we_d    = 1'b1;
            end
`ifdef VRAM_CLEAR_EN
            ST_CLEAR: begin
                ram_addr_d  = clr_cnt_q[ADDR_W-1:0];
                ram_wdata_d = FILL;
                ram_we_d    = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------- read return stage
    // state_q/fill_q carry the grant of the previous cycle, i.e. they tag the
    // ram_rdata now arriving. Writes ride the same pipe so they ack in N+2 too.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            fill_q      <= 1'b0;
            vid_valid_q <= 1'b0;
            vid_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            fill_q      <= fill_d;
            vid_valid_q <= (state_q == ST_VID) || fill_q;
            if (state_q == ST_VID) begin
                vid_rdata_q <= bus.ram_rdata;
            end else if (fill_q) begin
                vid_rdata_q <= FILL;
            end
            cpu_ack_q <= (state_q == ST_CPU_RD) || (state_q == ST_CPU_WR);
            if (state_q == ST_CPU_RD) begin
                cpu_rdata_q <= bus.ram_rdata;
            end
        end
    end

    assign bus.ram_addr  = ram_addr_d;
    assign bus.ram_wdata = ram_wdata_d;
    assign bus.ram_we    = ram_we_d;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.vid_valid = vid_valid_q;
    assign bus.vid_rdata = vid_rdata_q;
`ifdef VRAM_CLEAR_EN
    assign bus.clear_busy = clearing;
`else
    assign bus.clear_busy = 1'b0;
`endif

endmodule
